// File: rtl/cl_host_cmd_master.sv
// Camera Link serial command initiator: sends 8-byte register requests on ser_tx (UART 8N1)
// and collects the camera's 7-byte reply from ser_rx, one transaction at a time.
module cl_host_cmd_master #(
  parameter int unsigned CLK_DIV     = 217,
  parameter int unsigned TIMEOUT_CYC = 2500000
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_status,
  output logic [31:0] rsp_rdata,
  output logic [2:0]  rsp_err,
  output logic        busy,
  output logic        ser_tx,
  input  logic        ser_rx
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_TX, ST_RX_WAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  state_t          state;
  rx_state_t       rx_st;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]      bit_idx;
  logic [2:0]      byte_idx;
  logic            rd_q;
  logic [7:0]      addr_q;
  logic [31:0]     wdata_q;
  logic [TO_W-1:0] to_cnt;
  logic [2:0]      rx_idx;
  logic [7:0]      status_buf;
  logic [31:0]     data_buf;
  logic [7:0]      chk_acc;
  logic            err_framing;

  logic [1:0]       rx_sync;
  logic             rx_prev;
  logic             rx_s;
  logic [DIV_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic [7:0]       rx_byte;
  logic             rx_byte_vld;
  logic             rx_frm_err;

  logic [7:0] opcode_c;
  logic [7:0] tx_chk_c;
  logic [7:0] tx_byte_c;

  assign rx_s = rx_sync[1];

  // Request byte currently on the wire
  always_comb begin
    opcode_c  = rd_q ? 8'h02 : 8'h01;
    tx_chk_c  = opcode_c ^ addr_q ^ wdata_q[31:24] ^ wdata_q[23:16] ^ wdata_q[15:8] ^ wdata_q[7:0];
    tx_byte_c = 8'h55;
    case (byte_idx)
      3'd0:    tx_byte_c = 8'h55;
      3'd1:    tx_byte_c = opcode_c;
      3'd2:    tx_byte_c = addr_q;
      3'd3:    tx_byte_c = wdata_q[31:24];
      3'd4:    tx_byte_c = wdata_q[23:16];
      3'd5:    tx_byte_c = wdata_q[15:8];
      3'd6:    tx_byte_c = wdata_q[7:0];
      default: tx_byte_c = tx_chk_c;
    endcase
  end

  // Free-running UART receiver; emits one-cycle byte / framing-error strobes
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rx_sync     <= 2'b11;
      rx_prev     <= 1'b1;
      rx_st       <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_byte     <= '0;
      rx_byte_vld <= 1'b0;
      rx_frm_err  <= 1'b0;
    end else begin
      rx_sync     <= {rx_sync[0], ser_rx};
      rx_prev     <= rx_s;
      rx_byte_vld <= 1'b0;
      rx_frm_err  <= 1'b0;
      case (rx_st)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_st  <= RX_START;
            rx_cnt <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == DIV_W'(HALF - 1)) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_W'(CLK_DIV - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
            else                rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == DIV_W'(CLK_DIV - 1)) begin
            rx_cnt <= '0;
            rx_st  <= RX_IDLE;
            if (rx_s) begin
              rx_byte     <= rx_shift;
              rx_byte_vld <= 1'b1;
            end else begin
              rx_frm_err  <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Transaction FSM: request serialisation, reply parsing, timeout
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      ser_tx      <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_status  <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= '0;
      div_cnt     <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      to_cnt      <= '0;
      rx_idx      <= '0;
      status_buf  <= '0;
      data_buf    <= '0;
      chk_acc     <= '0;
      err_framing <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state       <= ST_TX;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            rd_q        <= cmd_rd;
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_rd ? 32'h0 : cmd_wdata;
            ser_tx      <= 1'b0;
            div_cnt     <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            err_framing <= 1'b0;
            status_buf  <= '0;
            data_buf    <= '0;
            chk_acc     <= '0;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_TX: begin
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx <= '0;
              if (byte_idx == 3'd7) begin
                state  <= ST_RX_WAIT;
                to_cnt <= '0;
                rx_idx <= '0;
              end else begin
                byte_idx <= byte_idx + 3'd1;
                ser_tx   <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              ser_tx  <= (bit_idx < 4'd8) ? tx_byte_c[bit_idx[2:0]] : 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_RX_WAIT: begin
          if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            state      <= ST_DONE;
            rsp_valid  <= 1'b1;
            rsp_status <= status_buf;
            rsp_rdata  <= data_buf;
            rsp_err    <= {err_framing | rx_frm_err, 2'b01};
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (rx_frm_err) err_framing <= 1'b1;
            if (rx_byte_vld) begin
              case (rx_idx)
                3'd0: if (rx_byte == 8'hAA) rx_idx <= 3'd1;
                3'd1: begin
                  status_buf <= rx_byte;
                  chk_acc    <= chk_acc ^ rx_byte;
                  rx_idx     <= rx_idx + 3'd1;
                end
                3'd2, 3'd3, 3'd4, 3'd5: begin
                  data_buf <= {data_buf[23:0], rx_byte};
                  chk_acc  <= chk_acc ^ rx_byte;
                  rx_idx   <= rx_idx + 3'd1;
                end
                default: begin
                  state      <= ST_DONE;
                  rsp_valid  <= 1'b1;
                  rsp_status <= status_buf;
                  rsp_rdata  <= data_buf;
                  rsp_err    <= {err_framing, chk_acc != rx_byte, 1'b0};
                end
              endcase
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cl_host_cmd_master.sv
// Directed bench for cl_host_cmd_master: decodes the request on ser_tx, plays camera replies on ser_rx.
module tb_cl_host_cmd_master;

  localparam int unsigned DIV = 8;
  localparam int unsigned TO  = 1000;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_status;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_err;
  logic        busy;
  logic        ser_tx;
  logic        ser_rx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rv_count = 0;
  int rv_cyc = 0;
  logic [7:0]  rv_status;
  logic [31:0] rv_rdata;
  logic [2:0]  rv_err;

  cl_host_cmd_master #(.CLK_DIV(DIV), .TIMEOUT_CYC(TO)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .ser_tx(ser_tx), .ser_rx(ser_rx)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Records every rsp_valid cycle with the response fields present on it
  always @(posedge clk_sys) begin
    if (rsp_valid === 1'b1) begin
      rv_count  = rv_count + 1;
      rv_cyc    = cyc;
      rv_status = rsp_status;
      rv_rdata  = rsp_rdata;
      rv_err    = rsp_err;
    end
  end

  task automatic issue(input logic rd, input logic [7:0] addr, input logic [31:0] wd, input string tag);
    @(negedge clk_sys);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s cmd_ready before issue: got %b want 1", tag, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = addr; cmd_wdata = wd;
    @(negedge clk_sys);
    cmd_valid = 1'b0; cmd_wdata = 32'h0; cmd_addr = 8'h0;
    n_cmp++;
    if ({busy, cmd_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL %s busy/cmd_ready after accept: got %b%b want 10", tag, busy, cmd_ready);
    end
  endtask

  task automatic capture_req(input logic [7:0] exp_b [8], input string tag, output int end_cyc);
    int w = 0;
    int start;
    int off = 0;
    logic [9:0] fr;
    while (ser_tx !== 1'b0 && w < 100) begin
      @(negedge clk_sys);
      w++;
    end
    n_cmp++;
    if (ser_tx !== 1'b0) begin
      n_err++;
      $display("FAIL %s request start bit: got ser_tx=%b want 0", tag, ser_tx);
      end_cyc = cyc;
      return;
    end
    start = cyc;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 10; j++) begin
        int target = 80 * k + 8 * j + 4;
        repeat (target - off) @(negedge clk_sys);
        off = target;
        fr[j] = ser_tx;
      end
      n_cmp++;
      if (fr !== {1'b1, exp_b[k], 1'b0}) begin
        n_err++;
        $display("FAIL %s request byte %0d: got frame %b want %b", tag, k, fr, {1'b1, exp_b[k], 1'b0});
      end
    end
    repeat (640 - off) @(negedge clk_sys);
    end_cyc = start + 640;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    ser_rx = 1'b0;
    repeat (DIV) @(negedge clk_sys);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (DIV) @(negedge clk_sys);
    end
    ser_rx = stop;
    repeat (DIV) @(negedge clk_sys);
    ser_rx = 1'b1;
  endtask

  task automatic send_reply(input logic [7:0] r [7]);
    for (int i = 0; i < 7; i++) send_byte(r[i], 1'b1);
  endtask

  task automatic wait_rsp(input int prev, input string tag);
    int w = 0;
    while (rv_count == prev && w < 4000) begin
      @(negedge clk_sys);
      w++;
    end
    repeat (5) @(negedge clk_sys);
    n_cmp++;
    if (rv_count != prev + 1) begin
      n_err++;
      $display("FAIL %s rsp_valid pulses: got %0d want 1", tag, rv_count - prev);
    end
    n_cmp++;
    if ({busy, cmd_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL %s busy/cmd_ready after done: got %b%b want 01", tag, busy, cmd_ready);
    end
  endtask

  task automatic test_reset;
    rst_sys_n = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = '0; cmd_wdata = '0; ser_rx = 1'b1;
    repeat (3) @(negedge clk_sys);
    n_cmp++;
    if ({cmd_ready, busy, ser_tx, rsp_valid} !== 4'b0010) begin
      n_err++;
      $display("FAIL reset ctrl {ready,busy,tx,valid}: got %b want 0010", {cmd_ready, busy, ser_tx, rsp_valid});
    end
    n_cmp++;
    if ({rsp_status, rsp_rdata, rsp_err} !== 43'h0) begin
      n_err++;
      $display("FAIL reset rsp: got status %h rdata %h err %b want zeros", rsp_status, rsp_rdata, rsp_err);
    end
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
    n_cmp++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL reset release ready/busy: got %b%b want 10", cmd_ready, busy);
    end
  endtask

  task automatic test_write;
    logic [7:0] e [8] = '{8'h55, 8'h01, 8'h10, 8'h00, 8'h12, 8'h34, 8'h56, 8'h61};
    logic [7:0] r [7] = '{8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    int prev = rv_count;
    int ec;
    issue(1'b0, 8'h10, 32'h0012_3456, "write");
    capture_req(e, "write", ec);
    send_reply(r);
    wait_rsp(prev, "write");
    n_cmp++;
    if ({rv_status, rv_rdata, rv_err} !== {8'h00, 32'h0, 3'b000}) begin
      n_err++;
      $display("FAIL write rsp: got status %h rdata %h err %b want 00 00000000 000", rv_status, rv_rdata, rv_err);
    end
  endtask

  task automatic test_read(input string tag, input logic [7:0] chk, input logic garbage,
                           input logic [2:0] exp_err);
    logic [7:0] e [8] = '{8'h55, 8'h02, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22};
    logic [7:0] r [7] = '{8'hAA, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    int prev = rv_count;
    int ec;
    r[6] = chk;
    issue(1'b1, 8'h20, 32'hFFFF_FFFF, tag);
    capture_req(e, tag, ec);
    if (garbage) send_byte(8'h13, 1'b1);
    send_reply(r);
    wait_rsp(prev, tag);
    n_cmp++;
    if ({rv_status, rv_rdata, rv_err} !== {8'h00, 32'hDEAD_BEEF, exp_err}) begin
      n_err++;
      $display("FAIL %s rsp: got status %h rdata %h err %b want 00 deadbeef %b", tag, rv_status, rv_rdata, rv_err, exp_err);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] e [8] = '{8'h55, 8'h01, 8'h33, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h32};
    int prev = rv_count;
    int ec;
    issue(1'b0, 8'h33, 32'hA5A5_A5A5, "timeout");
    capture_req(e, "timeout", ec);
    repeat (100) @(negedge clk_sys);
    cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = 8'h77;
    @(negedge clk_sys);
    cmd_valid = 1'b0;
    wait_rsp(prev, "timeout");
    n_cmp++;
    if (rv_cyc - ec != 1000) begin
      n_err++;
      $display("FAIL timeout latency: got %0d cycles want 1000", rv_cyc - ec);
    end
    n_cmp++;
    if ({rv_status, rv_rdata, rv_err} !== {8'h00, 32'h0, 3'b001}) begin
      n_err++;
      $display("FAIL timeout rsp: got status %h rdata %h err %b want 00 00000000 001", rv_status, rv_rdata, rv_err);
    end
    n_cmp++;
    if ({ser_tx, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL timeout ignored cmd: got ser_tx %b busy %b want 1 0", ser_tx, busy);
    end
  endtask

  task automatic test_framing;
    logic [7:0] e [8] = '{8'h55, 8'h02, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22};
    int prev = rv_count;
    int ec;
    issue(1'b1, 8'h20, 32'h0, "framing");
    capture_req(e, "framing", ec);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (2 * DIV) @(negedge clk_sys);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_rsp(prev, "framing");
    n_cmp++;
    if ({rv_status, rv_rdata, rv_err} !== {8'hDE, 32'hADBE_EF22, 3'b101}) begin
      n_err++;
      $display("FAIL framing rsp: got status %h rdata %h err %b want de adbeef22 101", rv_status, rv_rdata, rv_err);
    end
  endtask

  task automatic test_reset_mid_tx;
    int prev;
    issue(1'b0, 8'h10, 32'h0012_3456, "rst_mid");
    repeat (20) @(negedge clk_sys);
    prev = rv_count;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid busy before reset: got %b want 1", busy);
    end
    #2 rst_sys_n = 1'b0;
    #1;
    n_cmp++;
    if ({ser_tx, busy, cmd_ready} !== 3'b100) begin
      n_err++;
      $display("FAIL rst_mid async {tx,busy,ready}: got %b want 100", {ser_tx, busy, cmd_ready});
    end
    repeat (3) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    repeat (200) @(negedge clk_sys);
    n_cmp++;
    if (rv_count != prev || ser_tx !== 1'b1 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid after release: got pulses %0d tx %b ready %b want 0 1 1", rv_count - prev, ser_tx, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read("read", 8'h22, 1'b0, 3'b000);
    test_read("chk_bad", 8'h23, 1'b0, 3'b010);
    test_timeout();
    test_read("garbage", 8'h22, 1'b1, 3'b000);
    test_framing();
    test_reset_mid_tx();
    test_read("after_reset", 8'h22, 1'b0, 3'b000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
